mux_arbitro: RTL and testbench

- Two-source round-robin arbiter with a burst limit, built around a 2:1 selector and a registered output stage.
- Shares one downstream 2-bit channel between source 0 and source 1 using valid/ready handshakes.
- Exports its grant on `selector` so it can also sequence an external 2:1 mux.
- Sits between two producer blocks and a single consumer.

---
 rtl/mux_arbitro_if.sv | 28 ++
 rtl/mux_arbitro.sv | 108 ++++++++++
 tb/tb_mux_arbitro.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mux_arbitro_if.sv
// Bundle of the arbiter's source, sink and debug signals.
// The master side drives the producers and the consumer; the slave side is the arbiter itself.
interface mux_arbitro_if #(
    parameter int DATA_WIDTH = 2
);
    logic                  valid_in0;
    logic [DATA_WIDTH-1:0] data_in0;
    logic                  ready_out0;
    logic                  valid_in1;
    logic [DATA_WIDTH-1:0] data_in1;
    logic                  ready_out1;
    logic                  ready_in;
    logic                  valid_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  selector;
    logic [1:0]            dbg_state;
    logic [3:0]            dbg_cnt;

    modport master (
        output valid_in0, data_in0, valid_in1, data_in1, ready_in,
        input  ready_out0, ready_out1, valid_out, data_out, selector, dbg_state, dbg_cnt
    );

    modport slave (
        input  valid_in0, data_in0, valid_in1, data_in1, ready_in,
        output ready_out0, ready_out1, valid_out, data_out, selector, dbg_state, dbg_cnt
    );
endinterface

// File: rtl/mux_arbitro.sv
// Two-source round-robin arbiter with a burst limit, feeding one registered output stage.
// The combinational grant is exported on selector so it can steer an external 2:1 mux.
module mux_arbitro #(
    parameter int DATA_WIDTH = 2,
    parameter int BURST_MAX  = 4
) (
    input logic          clk,
    input logic          reset,
    mux_arbitro_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] BMAX = 4'(BURST_MAX);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  last_q, last_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic grant;
    logic can_load;
    logic rdy0;
    logic rdy1;

    // Handshake: a beat moves on a port only in a cycle where both its valid and its
    // ready are high; valid may not depend on ready, and held data must stay stable.
    assign can_load = !valid_q || bus.ready_in;
    assign rdy0     = can_load && !grant && bus.valid_in0 && !reset;
    assign rdy1     = can_load &&  grant && bus.valid_in1 && !reset;

    always_comb begin
        grant = last_q;
        if (bus.valid_in0 && !bus.valid_in1) begin
            grant = 1'b0;
        end else if (!bus.valid_in0 && bus.valid_in1) begin
            grant = 1'b1;
        end else if (bus.valid_in0 && bus.valid_in1) begin
            case (state_q)
                OWN0:    grant = (cnt_q == BMAX);
                OWN1:    grant = (cnt_q != BMAX);
                default: grant = !last_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        valid_d = valid_q;
        data_d  = data_q;
        if (rdy0) begin
            data_d  = bus.data_in0;
            valid_d = 1'b1;
            last_d  = 1'b0;
            if (state_q == OWN0) begin
                cnt_d = (cnt_q == BMAX) ? BMAX : cnt_q + 4'd1;
            end else begin
                state_d = OWN0;
                cnt_d   = 4'd1;
            end
        end else if (rdy1) begin
            data_d  = bus.data_in1;
            valid_d = 1'b1;
            last_d  = 1'b1;
            if (state_q == OWN1) begin
                cnt_d = (cnt_q == BMAX) ? BMAX : cnt_q + 4'd1;
            end else begin
                state_d = OWN1;
                cnt_d   = 4'd1;
            end
        end else if (can_load) begin
            // Nothing requested while the slot is free: drop ownership, keep stale data.
            state_d = IDLE;
            cnt_d   = 4'd0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            last_q  <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign bus.ready_out0 = rdy0;
    assign bus.ready_out1 = rdy1;
    assign bus.valid_out  = valid_q;
    assign bus.data_out   = data_q;
    assign bus.selector   = grant;
    assign bus.dbg_state  = state_q;
    assign bus.dbg_cnt    = cnt_q;
endmodule

// File: tb/tb_mux_arbitro.sv
// Vector-table bench for mux_arbitro: per-cycle grant/handshake expectations plus an
// expected-data queue filled on accepted beats and drained on completed output beats.
module tb_mux_arbitro;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    logic [1:0] exp_q[$];

    typedef struct {
        logic       rst;
        logic       v0;
        logic [1:0] d0;
        logic       v1;
        logic [1:0] d1;
        logic       rdy;
        logic       e_r0;
        logic       e_r1;
        logic       e_sel;
        logic       e_vout;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    mux_arbitro_if #(.DATA_WIDTH(2)) bus ();

    mux_arbitro #(.DATA_WIDTH(2), .BURST_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic rst, input logic v0, input logic [1:0] d0,
                                input logic v1, input logic [1:0] d1, input logic rdy,
                                input logic r0, input logic r1, input logic sel,
                                input logic vout, input logic [3:0] cnt);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.rdy = rdy;
        v.e_r0 = r0; v.e_r1 = r1; v.e_sel = sel; v.e_vout = vout; v.e_cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [7:0] act,
                         input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %0h, expected %0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset         = v.rst;
        bus.valid_in0 = v.v0;
        bus.data_in0  = v.d0;
        bus.valid_in1 = v.v1;
        bus.data_in1  = v.d1;
        bus.ready_in  = v.rdy;
    endtask

    initial begin
        logic       prev_rst;
        logic [1:0] exp_d;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.valid_in0 = 1'b0;
        bus.data_in0  = 2'd0;
        bus.valid_in1 = 1'b0;
        bus.data_in1  = 2'd0;
        bus.ready_in  = 1'b0;

        //                rst v0 d0 v1 d1 rdy  r0 r1 sel vout cnt
        // reset held with both sources requesting, then first grant to source 0
        vecs.push_back(mk(1, 1, 1, 1, 2, 1,   0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 2, 1,   0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 2, 1,   1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 2, 1,   1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 1, 2, 1,   1, 0, 0, 1, 2));
        vecs.push_back(mk(0, 1, 1, 1, 2, 1,   1, 0, 0, 1, 3));
        vecs.push_back(mk(0, 1, 1, 1, 2, 1,   0, 1, 1, 1, 4));
        vecs.push_back(mk(0, 1, 1, 1, 2, 1,   0, 1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 1, 1, 2, 1,   0, 1, 1, 1, 2));
        vecs.push_back(mk(0, 1, 1, 1, 2, 1,   0, 1, 1, 1, 3));
        vecs.push_back(mk(0, 1, 1, 1, 2, 1,   1, 0, 0, 1, 4));
        vecs.push_back(mk(0, 1, 1, 1, 2, 1,   1, 0, 0, 1, 1));
        // three stalled cycles mid-burst, then resume
        vecs.push_back(mk(0, 1, 1, 1, 2, 0,   0, 0, 0, 1, 2));
        vecs.push_back(mk(0, 1, 1, 1, 2, 0,   0, 0, 0, 1, 2));
        vecs.push_back(mk(0, 1, 1, 1, 2, 0,   0, 0, 0, 1, 2));
        vecs.push_back(mk(0, 1, 1, 1, 2, 1,   1, 0, 0, 1, 2));
        vecs.push_back(mk(0, 1, 1, 1, 2, 1,   1, 0, 0, 1, 3));
        vecs.push_back(mk(0, 1, 1, 1, 2, 1,   0, 1, 1, 1, 4));
        // source 1 alone streams past the burst limit, cnt saturates
        vecs.push_back(mk(0, 0, 0, 1, 1, 1,   0, 1, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 2, 1,   0, 1, 1, 1, 2));
        vecs.push_back(mk(0, 0, 0, 1, 3, 1,   0, 1, 1, 1, 3));
        vecs.push_back(mk(0, 0, 0, 1, 2, 1,   0, 1, 1, 1, 4));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1,   0, 1, 1, 1, 4));
        // source 0 joins: immediate switch; then an idle gap and pointer check
        vecs.push_back(mk(0, 1, 3, 1, 2, 1,   1, 0, 0, 1, 4));
        vecs.push_back(mk(0, 1, 2, 0, 0, 1,   1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 2));
        vecs.push_back(mk(0, 1, 1, 1, 3, 1,   0, 1, 1, 0, 0));
        // reset during the third beat of a source 0 burst
        vecs.push_back(mk(0, 1, 1, 0, 0, 1,   1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 2, 0, 0, 1,   1, 0, 0, 1, 1));
        vecs.push_back(mk(1, 1, 3, 0, 0, 1,   0, 0, 0, 1, 2));
        vecs.push_back(mk(0, 1, 1, 1, 2, 1,   1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 2, 1,   1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0));

        prev_rst = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            check("ready_out0", i, 8'(bus.ready_out0), 8'(vecs[i].e_r0));
            check("ready_out1", i, 8'(bus.ready_out1), 8'(vecs[i].e_r1));
            check("selector",   i, 8'(bus.selector),   8'(vecs[i].e_sel));
            check("valid_out",  i, 8'(bus.valid_out),  8'(vecs[i].e_vout));
            check("cnt",        i, 8'(bus.dbg_cnt),    8'(vecs[i].e_cnt));
            if (prev_rst) begin
                check("data_out_after_reset", i, 8'(bus.data_out), 8'h00);
            end
            if (vecs[i].rst) begin
                exp_q.delete();
            end else begin
                if (vecs[i].e_vout) begin
                    if (exp_q.size() == 0) begin
                        check("scoreboard_underflow", i, 8'(exp_q.size()), 8'h01);
                    end else if (vecs[i].rdy) begin
                        exp_d = exp_q.pop_front();
                        check("data_out", i, 8'(bus.data_out), 8'(exp_d));
                    end else begin
                        check("data_out_stalled", i, 8'(bus.data_out), 8'(exp_q[0]));
                    end
                end
                if (vecs[i].e_r0) exp_q.push_back(vecs[i].d0);
                else if (vecs[i].e_r1) exp_q.push_back(vecs[i].d1);
            end
            prev_rst = vecs[i].rst;
        end
        check("scoreboard_leftover", vecs.size(), 8'(exp_q.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
